// File: rtl/joy_db15_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the SNAC DB15 joystick link (adapter emulator and reader).
// Pad word bit order, MSB first on the wire: SL S F E D C B A U D L R.
package joy_db15_pkg;

    localparam int FRAME_BITS_DEF = 24;
    localparam int PAD_BITS       = 12;

    localparam int BTN_R  = 0;
    localparam int BTN_L  = 1;
    localparam int BTN_D  = 2;
    localparam int BTN_U  = 3;
    localparam int BTN_A  = 4;
    localparam int BTN_B  = 5;
    localparam int BTN_C  = 6;
    localparam int BTN_DD = 7;
    localparam int BTN_E  = 8;
    localparam int BTN_F  = 9;
    localparam int BTN_S  = 10;
    localparam int BTN_SL = 11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/joy_db15_tx_sync_edge.sv
`timescale 1ns/1ps
// Multi-stage synchroniser for an asynchronous strobe followed by one edge register.
// Reset value is 1 so a released (high) line produces no spurious edge after reset.
module joy_db15_tx_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   edge_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '1;
            edge_p1 <= 1'b1;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
            edge_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    assign level = sync_p0[SYNC_STAGES-1];
    assign rise  = level & ~edge_p1;
    assign fall  = ~level & edge_p1;

endmodule

// File: rtl/joy_db15_tx.sv
`timescale 1ns/1ps
// Emulates the DB15 adapter's parallel-in/serial-out register: loads both pad words while
// JOY_LOAD is low and shifts one bit out per synchronised JOY_CLK rising edge.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int SYNC_STAGES = 2,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic [11:0] joystick1,
    input  logic [11:0] joystick2,
    input  logic        JOY_CLK,
    input  logic        JOY_LOAD,
    output logic        JOY_DATA,
    output logic        frame_done,
    output logic [4:0]  bit_index
);

    localparam logic [4:0] LAST_IDX = 5'(FRAME_BITS - 1);

    logic clk_rise;
    logic load_level;
    logic load_lvl;
    logic clk_level_unused;
    logic clk_fall_unused;
    logic load_rise_unused;
    logic load_fall_unused;

    state_t                state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] pad_word;
    logic [FRAME_BITS-1:0] wire_word;

    joy_db15_tx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk   (clk),
        .rst_n (Reset_n),
        .din   (JOY_CLK),
        .level (clk_level_unused),
        .rise  (clk_rise),
        .fall  (clk_fall_unused)
    );

    joy_db15_tx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
        .clk   (clk),
        .rst_n (Reset_n),
        .din   (JOY_LOAD),
        .level (load_level),
        .rise  (load_rise_unused),
        .fall  (load_fall_unused)
    );

    assign load_lvl  = ~load_level;
    assign pad_word  = FRAME_BITS'({joystick1, joystick2});
    assign wire_word = ACTIVE_LOW ? ~pad_word : pad_word;

    // Load has priority over any shift in the same cycle, in every state.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            shift_reg  <= '1;
            bit_index  <= '0;
            frame_done <= 1'b0;
            JOY_DATA   <= 1'b1;
        end else begin
            frame_done <= 1'b0;
            if (load_lvl) begin
                state     <= LOAD;
                shift_reg <= wire_word;
                bit_index <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    LOAD: state <= SHIFT;
                    SHIFT: begin
                        if (clk_rise) begin
                            shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b1};
                            bit_index <= bit_index + 5'd1;
                            if (bit_index == LAST_IDX) begin
                                state      <= DONE;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (clk_rise)
                            shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b1};
                    end
                    default: state <= IDLE;
                endcase
            end
            JOY_DATA <= (state == IDLE || state == DONE) ? 1'b1 : shift_reg[FRAME_BITS-1];
        end
    end

endmodule
